risc_id_ex_reg: RTL and testbench
=================================

RISC_ID_EX_REG -- requirements
Module: RISC_id_ex_reg

Interface
REQ-001 Parameter: XLEN, 32, datapath width.
REQ-002 Parameter: RADDR_W, 5, register-index width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 validD  in  1  decode stage holds a real instruction.
REQ-006 aluControlD  in  3  ALU operation from the ALU decoder.
REQ-007 regWriteD, memWriteD, aluSrcD, branchD, jumpD  in  1 each  decoded control bits.
REQ-008 resultSrcD  in  2  writeback select; 2'b01 = load.
REQ-009 rd1D, rd2D, pcD, immExtD  in  XLEN each  operands, PC, extended immediate.
REQ-010 rs1D, rs2D, rdD  in  RADDR_W each  register indices.
REQ-011 flushE  in  1  branch/jump redirect; kill the instruction entering EX.
REQ-012 stallF, stallD  out  1 each  hold the fetch and decode registers (load-use).
REQ-013 All *E outputs  out  same width as the matching *D input  registered copies; validE also output.

Function
REQ-014 Each cycle the block SHALL capture every *D field into *E, giving one-cycle latency.
REQ-015 Load-use hazard SHALL be the condition: validE & resultSrcE==2'b01 & rdE!=0 & validD & (rdE==rs1D | rdE==rs2D).
REQ-016 The hazard SHALL be evaluated combinationally from the current E contents.
REQ-017 stallF and stallD SHALL equal the hazard term, and SHALL be forced to 0 when flushE=1.
REQ-018 On hazard, the block SHALL load a bubble: validE=0, regWriteE=memWriteE=branchE=jumpE=0, aluControlE=3'b000, resultSrcE=2'b00.
REQ-019 Data fields SHALL be don't-care in a bubble, but SHALL be zeroed.
REQ-020 flushE=1 SHALL load a bubble regardless of the hazard term; flush wins over a simultaneous hazard.
REQ-021 A bubble SHALL never itself cause a hazard (validE=0 on the next cycle), so a stall lasts exactly one cycle.
REQ-022 validD=0 SHALL propagate as a bubble with all control bits cleared.
REQ-023 rdE==0 SHALL never cause a stall, whatever rs1D/rs2D are.

Reset
REQ-024 While rst=1 at a clock edge, all *E outputs SHALL become 0, including validE.
REQ-025 stallF and stallD SHALL read 0 in the cycle after reset.
REQ-026 Reset SHALL take priority over flushE and the hazard term.
REQ-027 Reset asserted mid-stall SHALL drop the stall on the next edge.

Configuration
REQ-028 Macro RISC_IDEX_PERF_EN SHALL select the bubble-counter feature.
REQ-029 With the macro defined: 32-bit output bubbleCountE SHALL increment by 1 each cycle a bubble is loaded because of a hazard or flushE.
REQ-030 With the macro defined: bubbleCountE SHALL reset to 0, SHALL wrap 0xFFFFFFFF->0, and SHALL not count reset cycles.
REQ-031 Without the macro: the port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Shared package RISC_pkg SHALL hold: ALU control encodings (ADD=000, SUB=001, AND=010, OR=011, SLT=101), resultSrc encodings, XLEN and RADDR_W defaults.
REQ-033 Sub-module RISC_load_use_detect SHALL hold the combinational hazard term.
REQ-034 The register bank with bubble insertion SHALL live in the top module.

Verification
REQ-035 Scenario, plain capture: rst, then validD=1, aluControlD=3'b001, rd1D=0x5 -> next cycle aluControlE=001, rd1E=0x5, validE=1, stall=0.
REQ-036 Scenario, load-use: E holds a load with rdE=7; D has rs2D=7 -> stallF=stallD=1 for one cycle; next E is a bubble; the following cycle captures the D instruction.
REQ-037 Scenario, flush vs hazard: hazard and flushE=1 together -> stalls=0, bubble loaded, bubbleCountE+1 with RISC_IDEX_PERF_EN.
REQ-038 Scenario, x0 load: load with rdE=0, rs1D=0 -> no stall.
REQ-039 Scenario, reset mid-stall: hazard active, rst=1 -> next cycle all *E=0, stalls=0, counter=0.
REQ-040 Scenario, counter wrap: preload bubbleCountE=0xFFFFFFFF by force, inject one flush -> 0x00000000.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared encodings and defaults for the ID/EX pipeline register and its hazard logic.
package risc_pkg;

    localparam int unsigned XlenDef   = 32;
    localparam int unsigned RaddrWDef = 5;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        ResAlu  = 2'b00,
        ResLoad = 2'b01,
        ResPc   = 2'b10
    } result_src_e;

    // Control half of the EX stage; an all-zero value is a bubble.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [2:0] alu_control;
        logic [1:0] result_src;
    } ctrl_t;

    localparam ctrl_t CtrlBubble = '0;

    function automatic logic is_load(input logic [1:0] result_src);
        return result_src == ResLoad;
    endfunction

endpackage

// File: rtl/risc_load_use_detect.sv
// Combinational load-use hazard term between the instruction in EX and the one in decode.
module risc_load_use_detect
    import risc_pkg::*;
#(
    parameter int unsigned RADDR_W = RaddrWDef
) (
    input  logic               valid_e_i,
    input  logic [1:0]         result_src_e_i,
    input  logic [RADDR_W-1:0] rd_e_i,
    input  logic               valid_d_i,
    input  logic [RADDR_W-1:0] rs1_d_i,
    input  logic [RADDR_W-1:0] rs2_d_i,
    output logic               hazard_o
);

    logic rd_nonzero;
    logic rd_match;

    always_comb begin
        rd_nonzero = (rd_e_i != '0);
        rd_match   = (rd_e_i == rs1_d_i) | (rd_e_i == rs2_d_i);
        hazard_o   = valid_e_i & is_load(result_src_e_i) & rd_nonzero & valid_d_i & rd_match;
    end

endmodule

// File: rtl/risc_id_ex_reg.sv
// ID/EX pipeline register with load-use stall and flush bubble insertion.
// Optional bubble counter enabled by defining RISC_IDEX_PERF_EN.
module risc_id_ex_reg
    import risc_pkg::*;
#(
    parameter int unsigned XLEN    = XlenDef,
    parameter int unsigned RADDR_W = RaddrWDef
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_d_i,
    input  logic [2:0]         alu_control_d_i,
    input  logic               reg_write_d_i,
    input  logic               mem_write_d_i,
    input  logic               alu_src_d_i,
    input  logic               branch_d_i,
    input  logic               jump_d_i,
    input  logic [1:0]         result_src_d_i,
    input  logic [XLEN-1:0]    rd1_d_i,
    input  logic [XLEN-1:0]    rd2_d_i,
    input  logic [XLEN-1:0]    pc_d_i,
    input  logic [XLEN-1:0]    imm_ext_d_i,
    input  logic [RADDR_W-1:0] rs1_d_i,
    input  logic [RADDR_W-1:0] rs2_d_i,
    input  logic [RADDR_W-1:0] rd_d_i,
    input  logic               flush_e_i,
    output logic               stall_f_o,
    output logic               stall_d_o,
`ifdef RISC_IDEX_PERF_EN
    output logic [31:0]        bubble_count_e_o,
`endif
    output logic               valid_e_o,
    output logic [2:0]         alu_control_e_o,
    output logic               reg_write_e_o,
    output logic               mem_write_e_o,
    output logic               alu_src_e_o,
    output logic               branch_e_o,
    output logic               jump_e_o,
    output logic [1:0]         result_src_e_o,
    output logic [XLEN-1:0]    rd1_e_o,
    output logic [XLEN-1:0]    rd2_e_o,
    output logic [XLEN-1:0]    pc_e_o,
    output logic [XLEN-1:0]    imm_ext_e_o,
    output logic [RADDR_W-1:0] rs1_e_o,
    output logic [RADDR_W-1:0] rs2_e_o,
    output logic [RADDR_W-1:0] rd_e_o
);

    ctrl_t              ctrl_q, ctrl_d;
    logic [XLEN-1:0]    rd1_q, rd1_d;
    logic [XLEN-1:0]    rd2_q, rd2_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    imm_q, imm_d;
    logic [RADDR_W-1:0] rs1_q, rs1_d;
    logic [RADDR_W-1:0] rs2_q, rs2_d;
    logic [RADDR_W-1:0] rd_q, rd_d;

    logic hazard;
    logic kill;

    risc_load_use_detect #(
        .RADDR_W (RADDR_W)
    ) u_load_use_detect (
        .valid_e_i      (ctrl_q.valid),
        .result_src_e_i (ctrl_q.result_src),
        .rd_e_i         (rd_q),
        .valid_d_i      (valid_d_i),
        .rs1_d_i        (rs1_d_i),
        .rs2_d_i        (rs2_d_i),
        .hazard_o       (hazard)
    );

    // A redirect discards the decode instruction, so there is nothing left to hold.
    assign stall_f_o = hazard & ~flush_e_i;
    assign stall_d_o = hazard & ~flush_e_i;
    assign kill      = hazard | flush_e_i;

    // Bubbles (kill or an empty decode slot) zero data as well as control.
    always_comb begin
        ctrl_d = CtrlBubble;
        rd1_d  = '0;
        rd2_d  = '0;
        pc_d   = '0;
        imm_d  = '0;
        rs1_d  = '0;
        rs2_d  = '0;
        rd_d   = '0;
        if (valid_d_i && !kill) begin
            ctrl_d.valid       = 1'b1;
            ctrl_d.reg_write   = reg_write_d_i;
            ctrl_d.mem_write   = mem_write_d_i;
            ctrl_d.alu_src     = alu_src_d_i;
            ctrl_d.branch      = branch_d_i;
            ctrl_d.jump        = jump_d_i;
            ctrl_d.alu_control = alu_control_d_i;
            ctrl_d.result_src  = result_src_d_i;
            rd1_d              = rd1_d_i;
            rd2_d              = rd2_d_i;
            pc_d               = pc_d_i;
            imm_d              = imm_ext_d_i;
            rs1_d              = rs1_d_i;
            rs2_d              = rs2_d_i;
            rd_d               = rd_d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q <= CtrlBubble;
            rd1_q  <= '0;
            rd2_q  <= '0;
            pc_q   <= '0;
            imm_q  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            pc_q   <= pc_d;
            imm_q  <= imm_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            rd_q   <= rd_d;
        end
    end

`ifdef RISC_IDEX_PERF_EN
    logic [31:0] bubble_count_q, bubble_count_d;

    // Only hazard/flush bubbles count; empty decode slots do not.
    always_comb begin
        bubble_count_d = bubble_count_q;
        if (kill) begin
            bubble_count_d = bubble_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_count_q <= '0;
        end else begin
            bubble_count_q <= bubble_count_d;
        end
    end

    assign bubble_count_e_o = bubble_count_q;
`endif

    assign valid_e_o       = ctrl_q.valid;
    assign alu_control_e_o = ctrl_q.alu_control;
    assign reg_write_e_o   = ctrl_q.reg_write;
    assign mem_write_e_o   = ctrl_q.mem_write;
    assign alu_src_e_o     = ctrl_q.alu_src;
    assign branch_e_o      = ctrl_q.branch;
    assign jump_e_o        = ctrl_q.jump;
    assign result_src_e_o  = ctrl_q.result_src;
    assign rd1_e_o         = rd1_q;
    assign rd2_e_o         = rd2_q;
    assign pc_e_o          = pc_q;
    assign imm_ext_e_o     = imm_q;
    assign rs1_e_o         = rs1_q;
    assign rs2_e_o         = rs2_q;
    assign rd_e_o          = rd_q;

endmodule

// File: tb/tb_risc_id_ex_reg.sv
// Table-driven bench for risc_id_ex_reg plus reset-mid-stall and counter-wrap sequences.
module tb_risc_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_d, reg_write_d, mem_write_d, alu_src_d, branch_d, jump_d, flush_e;
    logic [2:0]  alu_control_d;
    logic [1:0]  result_src_d;
    logic [31:0] rd1_d, rd2_d, pc_d, imm_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        stall_f, stall_d;
    logic        valid_e, reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e;
    logic [2:0]  alu_control_e;
    logic [1:0]  result_src_e;
    logic [31:0] rd1_e, rd2_e, pc_e, imm_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
`ifdef RISC_IDEX_PERF_EN
    logic [31:0] bubble_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    risc_id_ex_reg dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .valid_d_i       (valid_d),
        .alu_control_d_i (alu_control_d),
        .reg_write_d_i   (reg_write_d),
        .mem_write_d_i   (mem_write_d),
        .alu_src_d_i     (alu_src_d),
        .branch_d_i      (branch_d),
        .jump_d_i        (jump_d),
        .result_src_d_i  (result_src_d),
        .rd1_d_i         (rd1_d),
        .rd2_d_i         (rd2_d),
        .pc_d_i          (pc_d),
        .imm_ext_d_i     (imm_d),
        .rs1_d_i         (rs1_d),
        .rs2_d_i         (rs2_d),
        .rd_d_i          (rd_d),
        .flush_e_i       (flush_e),
        .stall_f_o       (stall_f),
        .stall_d_o       (stall_d),
`ifdef RISC_IDEX_PERF_EN
        .bubble_count_e_o(bubble_count),
`endif
        .valid_e_o       (valid_e),
        .alu_control_e_o (alu_control_e),
        .reg_write_e_o   (reg_write_e),
        .mem_write_e_o   (mem_write_e),
        .alu_src_e_o     (alu_src_e),
        .branch_e_o      (branch_e),
        .jump_e_o        (jump_e),
        .result_src_e_o  (result_src_e),
        .rd1_e_o         (rd1_e),
        .rd2_e_o         (rd2_e),
        .pc_e_o          (pc_e),
        .imm_ext_e_o     (imm_e),
        .rs1_e_o         (rs1_e),
        .rs2_e_o         (rs2_e),
        .rd_e_o          (rd_e)
    );

    typedef struct {
        logic        valid;
        logic [2:0]  alu;
        logic        regw, memw, alusrc, branch, jump;
        logic [1:0]  rsrc;
        logic [31:0] rd1, rd2, pc, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        flush;
        logic        exp_stall;
        logic        exp_bubble;
        logic        cnt_inc;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        valid_d       = v.valid;
        alu_control_d = v.alu;
        reg_write_d   = v.regw;
        mem_write_d   = v.memw;
        alu_src_d     = v.alusrc;
        branch_d      = v.branch;
        jump_d        = v.jump;
        result_src_d  = v.rsrc;
        rd1_d         = v.rd1;
        rd2_d         = v.rd2;
        pc_d          = v.pc;
        imm_d         = v.imm;
        rs1_d         = v.rs1;
        rs2_d         = v.rs2;
        rd_d          = v.rd;
        flush_e       = v.flush;
    endtask

    // Expect E to hold v exactly, or all zeros when bubble is set.
    task automatic check_e(input string tag, input vec_t v, input logic bubble);
        vec_t z;
        z = v;
        if (bubble) begin
            z.valid = 0; z.alu = 0; z.regw = 0; z.memw = 0; z.alusrc = 0; z.branch = 0;
            z.jump = 0; z.rsrc = 0; z.rd1 = 0; z.rd2 = 0; z.pc = 0; z.imm = 0;
            z.rs1 = 0; z.rs2 = 0; z.rd = 0;
        end
        check({tag, ".valid"}, 32'(valid_e), 32'(z.valid));
        check({tag, ".alu"}, 32'(alu_control_e), 32'(z.alu));
        check({tag, ".ctrl"}, 32'({reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e}),
              32'({z.regw, z.memw, z.alusrc, z.branch, z.jump}));
        check({tag, ".rsrc"}, 32'(result_src_e), 32'(z.rsrc));
        check({tag, ".rd1"}, rd1_e, z.rd1);
        check({tag, ".rd2"}, rd2_e, z.rd2);
        check({tag, ".pc"}, pc_e, z.pc);
        check({tag, ".imm"}, imm_e, z.imm);
        check({tag, ".regidx"}, 32'({rs1_e, rs2_e, rd_e}), 32'({z.rs1, z.rs2, z.rd}));
    endtask

    initial begin
        vec_t v;
        int   exp_cnt;
        exp_cnt = 0;
        // valid alu regw memw alusrc br jmp rsrc rd1 rd2 pc imm rs1 rs2 rd flush | stall bubble cnt
        tbl[0]  = '{1, 3'b001, 1, 0, 0, 0, 0, 2'b00, 32'h5, 32'h0, 32'h100, 32'h0,
                    5'd1, 5'd2, 5'd3, 0, 0, 0, 0};
        tbl[1]  = '{1, 3'b000, 1, 0, 1, 0, 0, 2'b01, 32'h1000, 32'h0, 32'h104, 32'h8,
                    5'd1, 5'd0, 5'd7, 0, 0, 0, 0};
        tbl[2]  = '{1, 3'b010, 1, 0, 0, 0, 0, 2'b00, 32'h11, 32'h22, 32'h108, 32'h0,
                    5'd4, 5'd7, 5'd8, 0, 1, 1, 1};
        tbl[3]  = '{1, 3'b010, 1, 0, 0, 0, 0, 2'b00, 32'h11, 32'h22, 32'h108, 32'h0,
                    5'd4, 5'd7, 5'd8, 0, 0, 0, 0};
        tbl[4]  = '{1, 3'b000, 1, 0, 1, 0, 0, 2'b01, 32'h2000, 32'h0, 32'h10c, 32'h4,
                    5'd2, 5'd0, 5'd0, 0, 0, 0, 0};
        tbl[5]  = '{1, 3'b011, 1, 0, 0, 0, 0, 2'b00, 32'h3, 32'h4, 32'h110, 32'h0,
                    5'd0, 5'd0, 5'd6, 0, 0, 0, 0};
        tbl[6]  = '{1, 3'b000, 1, 0, 1, 0, 0, 2'b01, 32'h3000, 32'h0, 32'h114, 32'hc,
                    5'd1, 5'd1, 5'd9, 0, 0, 0, 0};
        tbl[7]  = '{1, 3'b101, 1, 0, 0, 0, 0, 2'b00, 32'h7, 32'h8, 32'h118, 32'h0,
                    5'd9, 5'd3, 5'd10, 1, 0, 1, 1};
        tbl[8]  = '{0, 3'b011, 1, 1, 1, 1, 1, 2'b10, 32'hdead, 32'hbeef, 32'h11c, 32'h10,
                    5'd1, 5'd2, 5'd3, 0, 0, 1, 0};
        tbl[9]  = '{1, 3'b000, 1, 0, 1, 0, 0, 2'b01, 32'h4000, 32'h0, 32'h120, 32'h0,
                    5'd3, 5'd0, 5'd5, 0, 0, 0, 0};
        tbl[10] = '{0, 3'b001, 1, 0, 0, 0, 0, 2'b00, 32'h1, 32'h2, 32'h124, 32'h0,
                    5'd5, 5'd5, 5'd6, 0, 0, 1, 0};
        tbl[11] = '{1, 3'b001, 1, 1, 0, 1, 1, 2'b10, 32'h9, 32'ha, 32'h128, 32'h1,
                    5'd1, 5'd2, 5'd3, 1, 0, 1, 1};
        tbl[12] = '{1, 3'b101, 1, 1, 1, 1, 1, 2'b10, 32'hffffffff, 32'h80000000, 32'hfffffffc,
                    32'hffffff00, 5'd31, 5'd30, 5'd29, 0, 0, 0, 0};
        tbl[13] = '{1, 3'b000, 1, 0, 1, 0, 0, 2'b01, 32'h5000, 32'h0, 32'h12c, 32'h0,
                    5'd0, 5'd0, 5'd31, 0, 0, 0, 0};
        tbl[14] = '{1, 3'b000, 0, 1, 1, 0, 0, 2'b00, 32'h6, 32'h7, 32'h130, 32'h20,
                    5'd31, 5'd0, 5'd2, 0, 1, 1, 1};
        tbl[15] = '{1, 3'b000, 0, 1, 1, 0, 0, 2'b00, 32'h6, 32'h7, 32'h130, 32'h20,
                    5'd31, 5'd0, 5'd2, 0, 0, 0, 0};

        // Reset with busy inputs and a flush: reset must win.
        v = tbl[12];
        v.flush = 1;
        drive(v);
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check_e("reset", tbl[0], 1'b1);
        rst = 0;
        drive(tbl[0]);
        #1;
        check("reset.stall_f", 32'(stall_f), 32'd0);
        check("reset.stall_d", 32'(stall_d), 32'd0);
`ifdef RISC_IDEX_PERF_EN
        check("reset.count", bubble_count, 32'd0);
`endif

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i]);
            #1;
            check($sformatf("v%0d.stall_f", i), 32'(stall_f), 32'(tbl[i].exp_stall));
            check($sformatf("v%0d.stall_d", i), 32'(stall_d), 32'(tbl[i].exp_stall));
            @(posedge clk);
            #1;
            check_e($sformatf("v%0d", i), tbl[i], tbl[i].exp_bubble);
            if (tbl[i].cnt_inc) exp_cnt++;
`ifdef RISC_IDEX_PERF_EN
            check($sformatf("v%0d.count", i), bubble_count, 32'(exp_cnt));
`endif
        end

        // Reset asserted while a load-use stall is active.
        drive(tbl[1]);
        @(posedge clk);
        #1;
        v = tbl[3];
        v.rs1 = 5'd7;
        v.rs2 = 5'd0;
        drive(v);
        #1;
        check("rststall.pre_stall", 32'(stall_f), 32'd1);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        check_e("rststall", v, 1'b1);
        check("rststall.stall_f", 32'(stall_f), 32'd0);
        check("rststall.stall_d", 32'(stall_d), 32'd0);
`ifdef RISC_IDEX_PERF_EN
        check("rststall.count", bubble_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        check_e("rststall.after", v, 1'b0);

`ifdef RISC_IDEX_PERF_EN
        // Counter wrap: preload all-ones, then one flush bubble.
        force dut.bubble_count_q = 32'hffffffff;
        #1;
        release dut.bubble_count_q;
        check("wrap.preload", bubble_count, 32'hffffffff);
        v = tbl[0];
        v.flush = 1;
        drive(v);
        @(posedge clk);
        #1;
        check("wrap.count", bubble_count, 32'h0);
        check_e("wrap", v, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
